stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller with BCD count, 1 s prescaler and FSM.
// Define STOPWATCH_LAP_EN to build in the lap (display freeze) feature.
module stopwatch_ctrl #(
  parameter int unsigned TICK_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic       tick,
  output logic       rollover,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       lap_active
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [31:0] TOP = 32'(TICK_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic        ss_q, clr_q;
  logic [3:0]  su_q, su_d, st_q, st_d;
  logic [3:0]  mu_q, mu_d, mt_q, mt_d;
  logic        ss_press, clr_press;
  logic        is_run, tick_w, at_max;

  assign ss_press  = start_stop & ~ss_q;
  assign clr_press = clear & ~clr_q;
  assign is_run    = (state_q == S_RUN);
  assign tick_w    = is_run && (presc_q == TOP);
  assign at_max    = (su_q == 4'd9) && (st_q == 4'd5) &&
                     (mu_q == 4'd9) && (mt_q == 4'd5);

  assign running  = is_run;
  assign tick     = tick_w;
  assign rollover = tick_w && at_max;

  always_comb begin
    state_d = state_q;
    if (clr_press) begin
      state_d = S_IDLE;
    end else if (ss_press) begin
      unique case (1'b1)
        (state_q == S_IDLE):  state_d = S_RUN;
        (state_q == S_RUN):   state_d = S_PAUSE;
        (state_q == S_PAUSE): state_d = S_RUN;
        default:              state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (clr_press)
      presc_d = '0;
    else if (is_run)
      presc_d = (presc_q == TOP) ? '0 : presc_q + 32'd1;
  end

  // Ripple BCD increment: each digit wraps only when all lower ones do.
  always_comb begin
    su_d = su_q;
    st_d = st_q;
    mu_d = mu_q;
    mt_d = mt_q;
    if (clr_press) begin
      su_d = '0;
      st_d = '0;
      mu_d = '0;
      mt_d = '0;
    end else if (tick_w) begin
      if (su_q != 4'd9) begin
        su_d = su_q + 4'd1;
      end else begin
        su_d = '0;
        if (st_q != 4'd5) begin
          st_d = st_q + 4'd1;
        end else begin
          st_d = '0;
          if (mu_q != 4'd9) begin
            mu_d = mu_q + 4'd1;
          end else begin
            mu_d = '0;
            mt_d = (mt_q != 4'd5) ? mt_q + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ss_q    <= 1'b0;
      clr_q   <= 1'b0;
      su_q    <= '0;
      st_q    <= '0;
      mu_q    <= '0;
      mt_q    <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ss_q    <= start_stop;
      clr_q   <= clear;
      su_q    <= su_d;
      st_q    <= st_d;
      mu_q    <= mu_d;
      mt_q    <= mt_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       lap_q, lap_press;
  logic       lact_q, lact_d;
  logic [7:0] lsec_q, lsec_d, lmin_q, lmin_d;

  assign lap_press = lap & ~lap_q;

  always_comb begin
    lact_d = lact_q;
    lsec_d = lsec_q;
    lmin_d = lmin_q;
    if (clr_press) begin
      lact_d = 1'b0;
    end else if (lap_press) begin
      if (is_run) begin
        lact_d = ~lact_q;
        if (!lact_q) begin
          lsec_d = {st_q, su_q};
          lmin_d = {mt_q, mu_q};
        end
      end else begin
        lact_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_q  <= 1'b0;
      lact_q <= 1'b0;
      lsec_q <= '0;
      lmin_q <= '0;
    end else begin
      lap_q  <= lap;
      lact_q <= lact_d;
      lsec_q <= lsec_d;
      lmin_q <= lmin_d;
    end
  end

  assign lap_active = lact_q;
  assign sec_bcd    = lact_q ? lsec_q : {st_q, su_q};
  assign min_bcd    = lact_q ? lmin_q : {mt_q, mu_q};
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign sec_bcd    = {st_q, su_q};
  assign min_bcd    = {mt_q, mu_q};
`endif

endmodule
